// File: rtl/reg8_bank_16bit.sv
// rtl/reg8_bank_16bit.sv - eight-entry register bank with addressed write port and sequenced clear
module reg8_bank_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [2:0]       address,
    input  logic [WIDTH-1:0] in,
    input  logic             clr_req,
    output logic             busy,
    output logic             drop,
    output logic [7:0]       valid_mask,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]       state;
    logic [2:0]       ptr;
    logic [WIDTH-1:0] regs [8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                regs[k] <= '0;
            end
            valid_mask <= 8'h00;
            busy       <= 1'b0;
            drop       <= 1'b0;
            ptr        <= 3'd0;
            state      <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    // A simultaneous write still lands; the sweep zeroes it later.
                    if (load) begin
                        regs[address]       <= in;
                        valid_mask[address] <= 1'b1;
                    end
                    if (clr_req) begin
                        state <= CLEAR;
                        ptr   <= 3'd0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    regs[ptr]       <= '0;
                    valid_mask[ptr] <= 1'b0;
                    ptr             <= ptr + 3'd1;
                    drop            <= load;
                    if (ptr == 3'd7) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    drop  <= 1'b0;
                end
            endcase
        end
    end

    assign r0 = regs[0];
    assign r1 = regs[1];
    assign r2 = regs[2];
    assign r3 = regs[3];
    assign r4 = regs[4];
    assign r5 = regs[5];
    assign r6 = regs[6];
    assign r7 = regs[7];

endmodule

// File: tb/tb_reg8_bank_16bit.sv
// tb/tb_reg8_bank_16bit.sv - self-checking bench for reg8_bank_16bit
module tb_reg8_bank_16bit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [2:0]  address = 3'd0;
    logic [15:0] in_d = 16'h0000;
    logic        clr_req = 1'b0;
    logic        busy, drop;
    logic [7:0]  valid_mask;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [15:0] rr [8];

    int checks = 0;
    int failures = 0;

    logic [15:0] m_r [8];
    logic [7:0]  m_vm = 8'h00;
    logic        m_busy = 1'b0;
    logic        m_drop = 1'b0;
    int          m_clear_left = 0;

    reg8_bank_16bit #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .load(load), .address(address), .in(in_d),
        .clr_req(clr_req), .busy(busy), .drop(drop), .valid_mask(valid_mask),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7)
    );

    assign rr[0] = r0; assign rr[1] = r1; assign rr[2] = r2; assign rr[3] = r3;
    assign rr[4] = r4; assign rr[5] = r5; assign rr[6] = r6; assign rr[7] = r7;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 8; k++) m_r[k] = 16'h0000;
        m_vm = 8'h00;
        m_busy = 1'b0;
        m_drop = 1'b0;
        m_clear_left = 0;
    endtask

    // Model: a clear is a countdown of remaining sweeps; entry (8-left) is zeroed each edge.
    task automatic model_step();
        if (m_clear_left > 0) begin
            m_r[8 - m_clear_left] = 16'h0000;
            m_vm[8 - m_clear_left] = 1'b0;
            m_clear_left = m_clear_left - 1;
            m_drop = load;
        end else begin
            m_drop = 1'b0;
            if (load) begin
                m_r[address] = in_d;
                m_vm[address] = 1'b1;
            end
            if (clr_req) m_clear_left = 8;
        end
        m_busy = (m_clear_left > 0);
    endtask

    always @(posedge clk) begin
        if (!reset) model_step();
        #1;
        if (!reset) begin
            for (int k = 0; k < 8; k++) chk($sformatf("model_r%0d", k), {16'h0, rr[k]}, {16'h0, m_r[k]});
            chk("model_valid_mask", {24'h0, valid_mask}, {24'h0, m_vm});
            chk("model_busy", {31'h0, busy}, {31'h0, m_busy});
            chk("model_drop", {31'h0, drop}, {31'h0, m_drop});
        end
    end

    task automatic step(input logic l, input logic [2:0] a, input logic [15:0] d, input logic c);
        load = l; address = a; in_d = d; clr_req = c;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cycle();
        step(1'b0, 3'd0, 16'h0000, 1'b0);
    endtask

    task automatic fill_bank();
        for (int k = 0; k < 8; k++) step(1'b1, 3'(k), 16'h1111 * 16'(k + 1), 1'b0);
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (busy && n < 20) begin
            idle_cycle();
            n++;
        end
        chk("clear_finishes", {31'h0, busy}, 32'h0);
    endtask

    int busy_cnt;

    initial begin
        model_clear();
        step(1'b0, 3'd0, 16'h0, 1'b0);
        step(1'b0, 3'd0, 16'h0, 1'b0);
        for (int k = 0; k < 8; k++) chk($sformatf("reset_r%0d", k), {16'h0, rr[k]}, 32'h0);
        chk("reset_valid_mask", {24'h0, valid_mask}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_drop", {31'h0, drop}, 32'h0);
        reset = 1'b0;

        // Sequential fill
        fill_bank();
        chk("fill_r7", {16'h0, r7}, 32'h8888);
        chk("fill_r0", {16'h0, r0}, 32'h1111);
        chk("fill_valid_mask", {24'h0, valid_mask}, 32'hFF);

        // Write then hold
        step(1'b1, 3'd5, 16'hBEEF, 1'b0);
        repeat (3) idle_cycle();
        chk("hold_r5", {16'h0, r5}, 32'hBEEF);
        chk("hold_r4", {16'h0, r4}, 32'h5555);
        chk("hold_r6", {16'h0, r6}, 32'h7777);

        // Full clear sweep
        step(1'b0, 3'd0, 16'h0, 1'b1);
        busy_cnt = busy ? 1 : 0;
        chk("clr_r0_before", {16'h0, r0}, 32'h1111);
        idle_cycle();
        if (busy) busy_cnt++;
        chk("clr_r0_first", {16'h0, r0}, 32'h0);
        chk("clr_r1_first", {16'h0, r1}, 32'h2222);
        for (int i = 2; i <= 8; i++) begin
            if (i == 8) chk("clr_r7_before_last", {16'h0, r7}, 32'h8888);
            idle_cycle();
            if (busy) busy_cnt++;
        end
        chk("clr_busy_cycles", busy_cnt, 32'd8);
        chk("clr_r7_last", {16'h0, r7}, 32'h0);
        chk("clr_valid_mask", {24'h0, valid_mask}, 32'h0);

        // Load during clear is dropped
        fill_bank();
        step(1'b0, 3'd0, 16'h0, 1'b1);
        idle_cycle();
        idle_cycle();
        step(1'b1, 3'd2, 16'h00AA, 1'b0);
        chk("drop_pulse", {31'h0, drop}, 32'h1);
        chk("drop_r2", {16'h0, r2}, 32'h0);
        chk("drop_vm2", {31'h0, valid_mask[2]}, 32'h0);
        idle_cycle();
        chk("drop_one_cycle", {31'h0, drop}, 32'h0);
        chk("drop_r2_after", {16'h0, r2}, 32'h0);
        wait_not_busy();

        // Write and clear at the same edge
        step(1'b1, 3'd3, 16'h1234, 1'b1);
        chk("same_r3", {16'h0, r3}, 32'h1234);
        busy_cnt = busy ? 1 : 0;
        for (int i = 1; i <= 8; i++) begin
            idle_cycle();
            if (busy) busy_cnt++;
            if (i == 3) chk("same_r3_held", {16'h0, r3}, 32'h1234);
            if (i == 4) chk("same_r3_zeroed", {16'h0, r3}, 32'h0);
        end
        chk("same_busy_cycles", busy_cnt, 32'd8);

        // Asynchronous reset mid-clear
        fill_bank();
        step(1'b0, 3'd0, 16'h0, 1'b1);
        repeat (4) idle_cycle();
        chk("mid_busy", {31'h0, busy}, 32'h1);
        #1;
        reset = 1'b1;
        model_clear();
        #1;
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_valid_mask", {24'h0, valid_mask}, 32'h0);
        for (int k = 0; k < 8; k++) chk($sformatf("arst_r%0d", k), {16'h0, rr[k]}, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        step(1'b1, 3'd6, 16'hABCD, 1'b0);
        chk("post_rst_r6", {16'h0, r6}, 32'hABCD);
        chk("post_rst_vm", {24'h0, valid_mask}, 32'h40);
        chk("post_rst_busy", {31'h0, busy}, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                 ($urandom_range(0, 15) == 0));
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
